// File: rtl/output_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : output_conditioner
// Purpose  : Turns one-cycle rise/fall request strobes into a glitch-free pin
//            level that holds each level for at least waittime cycles.
// Revision : 1.0 - initial release
// ============================================================================
module output_conditioner #(
    parameter int waittime     = 3,
    parameter int counterwidth = 3,
    parameter bit initlevel    = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rise,
    input  logic fall,
    output logic pin,
    output logic busy,
    output logic changed,
    output logic conflict
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [counterwidth-1:0] c_reload = counterwidth'(waittime - 1);

    state_t                  r_state, w_state_nxt;
    logic [counterwidth-1:0] r_cnt, w_cnt_nxt;
    logic                    r_pend_vld, w_pend_vld_nxt;
    logic                    r_pend_tgt, w_pend_tgt_nxt;
    logic                    r_pin, w_pin_nxt;
    logic                    r_changed, w_changed_nxt;
    logic                    r_conflict;

    logic w_req_vld;
    logic w_req_tgt;
    logic w_eff_vld;
    logic w_eff_tgt;

    // Simultaneous rise and fall is treated as no request at all.
    assign w_req_vld = rise ^ fall;
    assign w_req_tgt = rise;

    // A request in the expiry cycle takes precedence over the stored one.
    assign w_eff_vld = w_req_vld | r_pend_vld;
    assign w_eff_tgt = w_req_vld ? w_req_tgt : r_pend_tgt;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_tgt_nxt = r_pend_tgt;
        w_pin_nxt      = r_pin;
        w_changed_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req_vld && (w_req_tgt != r_pin)) begin
                    w_pin_nxt     = w_req_tgt;
                    w_cnt_nxt     = c_reload;
                    w_changed_nxt = 1'b1;
                    w_state_nxt   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_pend_vld_nxt = 1'b0;
                    if (w_eff_vld && (w_eff_tgt != r_pin)) begin
                        w_pin_nxt     = w_eff_tgt;
                        w_cnt_nxt     = c_reload;
                        w_changed_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (w_req_vld) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_tgt_nxt = w_req_tgt;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= 1'b0;
            r_pin      <= initlevel;
            r_changed  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_pin      <= w_pin_nxt;
            r_changed  <= w_changed_nxt;
            r_conflict <= rise & fall;
        end
    end

    assign pin      = r_pin;
    assign busy     = (r_state == ST_HOLD);
    assign changed  = r_changed;
    assign conflict = r_conflict;

endmodule
`default_nettype wire
